// File: rtl/mem_stage.sv
// Memory-access stage: issues word-aligned loads/stores to a variable-latency
// data memory over a strobe/busy/done handshake and stalls the pipeline while
// the access is in flight. Illegal accesses and timeouts set a sticky err.
//
// state | meaning
// IDLE  | no access in flight; a new access may strobe combinationally
// REQ   | memory was busy; strobe re-driven from latched values
// WAIT  | strobe accepted; waiting for memDone, timeout counter running
module mem_stage #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ALUResult,
    input  logic [15:0] writeData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        halt,
    output logic [15:0] memAddr,
    output logic [15:0] memWrData,
    output logic        memRd,
    output logic        memWr,
    input  logic        memBusy,
    input  logic        memDone,
    input  logic [15:0] memRdData,
    output logic [15:0] memData,
    output logic [15:0] ALUData,
    output logic        memStall,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic [15:0]      lat_addr;
    logic [15:0]      lat_data;
    logic             lat_rd;
    logic             lat_wr;

    logic access_req;
    logic bad_access;
    logic good_access;
    logic timed_out;

    // halt and the sticky error only gate new accesses taken from IDLE
    assign access_req  = (memRead | memWrite) & ~halt & ~err_q;
    assign bad_access  = access_req & (ALUResult[0] | (memRead & memWrite));
    assign good_access = access_req & ~bad_access;
    assign timed_out   = (cnt == CNT_LAST);

    assign ALUData = ALUResult;
    assign err     = err_q;

    // Strobes, stall and load data; IDLE strobes straight from the inputs
    // so a ready memory sees the request in the instruction's first cycle.
    always_comb begin
        memAddr   = lat_addr;
        memWrData = lat_data;
        memRd     = 1'b0;
        memWr     = 1'b0;
        memStall  = 1'b0;
        memData   = 16'h0000;
        unique case (state)
            IDLE: begin
                memAddr   = ALUResult;
                memWrData = writeData;
                memRd     = good_access & memRead;
                memWr     = good_access & memWrite;
                memStall  = good_access;
            end
            REQ: begin
                memRd    = lat_rd;
                memWr    = lat_wr;
                memStall = 1'b1;
            end
            WAIT: begin
                // memDone wins over a simultaneous timeout
                memStall = ~memDone & ~timed_out;
                if (memDone && lat_rd) begin
                    memData = memRdData;
                end
            end
            default: ;
        endcase
    end

    // State, timeout counter, sticky error and latched request
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            err_q    <= 1'b0;
            lat_addr <= 16'h0000;
            lat_data <= 16'h0000;
            lat_rd   <= 1'b0;
            lat_wr   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (good_access) begin
                        lat_addr <= ALUResult;
                        lat_data <= writeData;
                        lat_rd   <= memRead;
                        lat_wr   <= memWrite;
                        state    <= memBusy ? REQ : WAIT;
                    end else if (bad_access) begin
                        err_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (!memBusy) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (memDone) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (timed_out) begin
                        cnt   <= '0;
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
